// File: rtl/fme_interp_scheduler_pkg.sv
// Shared types and constants for the FME interpolation scheduler.
// Imported by the bus interface, the round-robin arbiter and the scheduler top.
package fme_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    FETCH,
    DRAIN,
    RUN,
    DONE
  } state_e;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

  localparam int unsigned SCHED_ROWS = 21;
  localparam int unsigned ROW_CNT_W  = $clog2(SCHED_ROWS);

endpackage

// File: rtl/fme_interp_scheduler_if.sv
// Requester, search-window memory and interpolation-engine signals of the scheduler.
// master = scheduler side, slave = requesters/memory/engine side.
interface fme_interp_scheduler_if
  import fme_sched_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ADDRWIDTH = 10
) ();

  logic [1:0]           req;
  logic [ADDRWIDTH-1:0] base_addr_0;
  logic [ADDRWIDTH-1:0] base_addr_1;
  logic [1:0]           grant;
  logic [1:0]           done;
  logic                 busy;

  logic                 mem_rd_en;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_rdata;
  logic [DATAWIDTH-1:0] row_data;
  logic                 row_valid;
  logic [ROW_CNT_W-1:0] row_index;

  logic                 interp_enable;
  logic                 ph_finished;
  logic                 pvpo_finished;
  logic                 pvso_finished;
  logic                 timeout_err;

  modport master (
    input  req, base_addr_0, base_addr_1, mem_rdata,
    input  ph_finished, pvpo_finished, pvso_finished,
    output grant, done, busy, mem_rd_en, mem_addr, row_data, row_valid, row_index,
    output interp_enable, timeout_err
  );

  modport slave (
    output req, base_addr_0, base_addr_1, mem_rdata,
    output ph_finished, pvpo_finished, pvso_finished,
    input  grant, done, busy, mem_rd_en, mem_addr, row_data, row_valid, row_index,
    input  interp_enable, timeout_err
  );

endinterface

// File: rtl/fme_interp_scheduler_arb.sv
// Two-way round-robin arbiter: with both requests pending, the requester not served
// last wins; the served pointer records the current grant when update is strobed.
module fme_rr_arbiter2
  import fme_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    grant       = 2'b00;
    grant[REQ0] = req[REQ0] & (~req[REQ1] | (last_q == 1'(REQ1)));
    grant[REQ1] = req[REQ1] & (~req[REQ0] | (last_q == 1'(REQ0)));
  end

  always_comb begin
    last_d = last_q;
    if (update && (grant != 2'b00)) begin
      last_d = grant[REQ1];
    end
  end

  // Pointer starts at requester 1 so requester 0 wins the first contended grant.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q <= 1'(REQ1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fme_interp_scheduler.sv
// Shares one interpolation engine between two search requesters: arbitrate, fetch rows,
// start the engine, wait for its three phases. Optional watchdog: FME_SCHED_WATCHDOG_EN.
module fme_interp_scheduler
  import fme_sched_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned ADDRWIDTH  = 10,
  parameter int unsigned ROWS       = SCHED_ROWS,
  parameter int unsigned ROW_STRIDE = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic                   clock,
  input logic                   reset,
  fme_interp_scheduler_if.master bus
);

  localparam logic [ROW_CNT_W-1:0] ROW_LAST = ROW_CNT_W'(ROWS - 1);
  localparam logic [ROW_CNT_W-1:0] ROW_ONE  = ROW_CNT_W'(1);
  localparam logic [ADDRWIDTH-1:0] STRIDE   = ADDRWIDTH'(ROW_STRIDE);

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic                 row_valid_q, row_valid_d;
  logic [ROW_CNT_W-1:0] row_index_q, row_index_d;
  logic [2:0]           flags_q, flags_d;

  logic [2:0]           fin_now;
  logic                 all_done;
  logic                 wd_expired;
  logic                 run_exit;
  logic                 fetching;
  logic [1:0]           arb_req, arb_grant;
  logic [DATAWIDTH-1:0] row_data;

  // Outside IDLE the arbiter only sees the owner, so its update records who was served.
  assign arb_req  = (state_q == IDLE) ? bus.req : grant_q;
  assign fin_now  = {bus.pvso_finished, bus.pvpo_finished, bus.ph_finished};
  assign all_done = &(flags_q | fin_now);
  assign run_exit = (state_q == RUN) && (all_done || wd_expired);
  assign fetching = (state_q == FETCH);

  fme_rr_arbiter2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (arb_req),
    .update (run_exit),
    .grant  (arb_grant)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    row_cnt_d   = row_cnt_q;
    flags_d     = flags_q;
    row_valid_d = fetching;
    row_index_d = fetching ? row_cnt_q : '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          state_d = GRANT;
          grant_d = arb_grant;
        end
      end
      GRANT: begin
        addr_d    = grant_q[REQ1] ? bus.base_addr_1 : bus.base_addr_0;
        row_cnt_d = '0;
        flags_d   = '0;
        state_d   = FETCH;
      end
      FETCH: begin
        addr_d    = addr_q + STRIDE;
        row_cnt_d = row_cnt_q + ROW_ONE;
        if (row_cnt_q == ROW_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = RUN;
      end
      RUN: begin
        flags_d = flags_q | fin_now;
        if (run_exit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      addr_q      <= '0;
      row_cnt_q   <= '0;
      row_valid_q <= 1'b0;
      row_index_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      row_cnt_q   <= row_cnt_d;
      row_valid_q <= row_valid_d;
      row_index_q <= row_index_d;
      flags_q     <= flags_d;
    end
  end

`ifdef FME_SCHED_WATCHDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       timeout_err_q, timeout_err_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == DRAIN) begin
      wd_cnt_d = '0;
    end else if (state_q == RUN) begin
      wd_cnt_d = wd_cnt_q + 8'd1;
    end
  end

  assign wd_expired    = (state_q == RUN) && (wd_cnt_d == WD_LIMIT) && !all_done;
  assign timeout_err_d = timeout_err_q | wd_expired;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign wd_expired      = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Memory read data is forwarded untouched alongside row_valid.
  assign row_data          = bus.mem_rdata;
  assign bus.row_data      = row_data;

  assign bus.grant         = grant_q;
  assign bus.done          = (state_q == DONE) ? grant_q : 2'b00;
  assign bus.busy          = (state_q != IDLE);
  assign bus.mem_rd_en     = fetching;
  assign bus.mem_addr      = fetching ? addr_q : '0;
  assign bus.row_valid     = row_valid_q;
  assign bus.row_index     = row_index_q;
  assign bus.interp_enable = (state_q == DRAIN);

endmodule

// File: tb/tb_fme_interp_scheduler.sv
// Scoreboard bench for fme_interp_scheduler; stimulus pushes timed expectations, a negedge
// monitor pops them on each DUT event. Watchdog branch selected by FME_SCHED_WATCHDOG_EN.
module tb_fme_interp_scheduler;

  typedef struct {
    logic [15:0] val;
    int          at;
  } exp_t;

  logic clock;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  exp_t exp_grant[$];
  exp_t exp_addr[$];
  exp_t exp_row[$];
  exp_t exp_en[$];
  exp_t exp_done[$];

  logic [1:0] prev_grant = 2'b00;
  logic [1:0] prev_done  = 2'b00;

  fme_interp_scheduler_if #(.DATAWIDTH(8), .ADDRWIDTH(10)) bus ();

  fme_interp_scheduler #(
    .DATAWIDTH  (8),
    .ADDRWIDTH  (10),
    .ROWS       (21),
    .ROW_STRIDE (32),
    .TIMEOUT    (255)
  ) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [15:0] v, input int t);
    exp_t e;
    e.val = v;
    e.at  = t;
    return e;
  endfunction

  function automatic logic [23:0] out_vec();
    return {bus.grant, bus.done, bus.busy, bus.mem_rd_en, bus.mem_addr, bus.row_valid,
            bus.row_index, bus.interp_enable, bus.timeout_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cmp_evt(input string name, input int have, input exp_t e, input logic [15:0] act);
    n_checks++;
    if (have == 0) begin
      $display("FAIL %s: unexpected event 0x%0h at cycle %0d, none required", name, act, cyc);
    end else if (act !== e.val || cyc != e.at) begin
      $display("FAIL %s: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d",
               name, act, cyc, e.val, e.at);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: every DUT output event consumes one expectation.
  always @(negedge clock) begin
    exp_t e;
    int   have;
    if (prev_done != 2'b00) chk("busy_after_done", {31'b0, bus.busy}, 32'd0);
    if (bus.grant != 2'b00 && prev_grant == 2'b00) begin
      have = exp_grant.size();
      if (have != 0) e = exp_grant.pop_front();
      cmp_evt("grant", have, e, {14'b0, bus.grant});
    end
    if (bus.mem_rd_en) begin
      have = exp_addr.size();
      if (have != 0) e = exp_addr.pop_front();
      cmp_evt("mem_addr", have, e, {6'b0, bus.mem_addr});
    end
    if (bus.row_valid) begin
      have = exp_row.size();
      if (have != 0) e = exp_row.pop_front();
      cmp_evt("row_index", have, e, {11'b0, bus.row_index});
    end
    if (bus.interp_enable) begin
      have = exp_en.size();
      if (have != 0) e = exp_en.pop_front();
      cmp_evt("interp_enable", have, e, {14'b0, bus.grant});
    end
    if (bus.done != 2'b00) begin
      have = exp_done.size();
      if (have != 0) e = exp_done.pop_front();
      cmp_evt("done", have, e, {14'b0, bus.done});
    end
    prev_grant = bus.grant;
    prev_done  = bus.done;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fin(input logic ph, input logic pvpo, input logic pvso);
    bus.ph_finished   = ph;
    bus.pvpo_finished = pvpo;
    bus.pvso_finished = pvso;
  endtask

  // Called in the cycle req is first presented with the DUT idle. Modes: 0 separate
  // finish pulses, 1 simultaneous, 2 pulses during DRAIN (ignored) then two RUN cycles,
  // 3 no finish pulses at all.
  task automatic do_job(input int owner, input logic [9:0] base, input int mode, input bit drop_req);
    int         c0;
    int         dc;
    logic [1:0] g;
    logic [9:0] a;
    c0 = cyc;
    g  = 2'b01 << owner;
    $display("job: owner=%0d base=0x%03h mode=%0d drop_req=%0d start_cycle=%0d",
             owner, base, mode, drop_req, c0);
    exp_grant.push_back(mk({14'b0, g}, c0 + 1));
    for (int k = 0; k < 21; k++) begin
      a = base + 10'(32 * k);
      exp_addr.push_back(mk({6'b0, a}, c0 + 2 + k));
      exp_row.push_back(mk(16'(k), c0 + 3 + k));
    end
    exp_en.push_back(mk({14'b0, g}, c0 + 23));
    repeat (23) begin
      step();
      if (drop_req && cyc == c0 + 5) bus.req = 2'b00;
    end
    if (mode == 2) set_fin(1'b1, 1'b1, 1'b1);
    step();
    set_fin(1'b0, 1'b0, 1'b0);
    dc = c0 + 26;
    case (mode)
      0: begin
        step(); set_fin(1'b0, 1'b0, 1'b1);
        step(); set_fin(1'b0, 1'b0, 1'b0);
        step(); set_fin(1'b1, 1'b0, 1'b0);
        step(); set_fin(1'b0, 1'b0, 1'b0);
        step(); set_fin(1'b0, 1'b1, 1'b0);
        dc = c0 + 30;
      end
      1: begin
        step(); set_fin(1'b1, 1'b1, 1'b1);
        dc = c0 + 26;
      end
      2: begin
        step();
        step(); set_fin(1'b1, 1'b1, 1'b0);
        step(); set_fin(1'b0, 1'b0, 1'b0);
        step(); set_fin(1'b0, 1'b0, 1'b1);
        dc = c0 + 29;
      end
      default: begin
`ifdef FME_SCHED_WATCHDOG_EN
        dc = c0 + 24 + 255;
`else
        repeat (300) step();
        chk("run_wait_busy", {31'b0, bus.busy}, 32'd1);
        chk("run_wait_timeout_err", {31'b0, bus.timeout_err}, 32'd0);
        set_fin(1'b1, 1'b1, 1'b1);
        dc = cyc + 1;
`endif
      end
    endcase
    exp_done.push_back(mk({14'b0, g}, dc));
    while (cyc < dc) begin
      step();
      set_fin(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int c0;
    int left;
    rst_n           = 1'b0;
    bus.req         = 2'b00;
    bus.base_addr_0 = 10'h000;
    bus.base_addr_1 = 10'h000;
    bus.mem_rdata   = 8'hA5;
    set_fin(1'b0, 1'b0, 1'b0);

    repeat (3) step();
    chk("reset_outputs", {8'b0, out_vec()}, 32'd0);
    chk("row_data_passthrough", {24'b0, bus.row_data}, 32'h0000_00A5);
    rst_n = 1'b1;
    step();
    chk("idle_not_busy", {31'b0, bus.busy}, 32'd0);

    // Single request, separate finish pulses.
    bus.base_addr_0 = 10'h040;
    bus.req         = 2'b01;
    do_job(0, 10'h040, 0, 1'b0);
    bus.req = 2'b00;
    step();

    // Simultaneous finish; owner drops req mid-fetch.
    bus.base_addr_0 = 10'h100;
    bus.req         = 2'b01;
    do_job(0, 10'h100, 1, 1'b1);
    bus.req = 2'b00;
    step();

    // Address wrap on requester 1; early finish pulses must be ignored.
    bus.base_addr_1 = 10'h3F0;
    bus.req         = 2'b10;
    do_job(1, 10'h3F0, 2, 1'b0);
    bus.req = 2'b00;
    step();

    // Contention with both requests held: 01, 10, 01.
    bus.base_addr_0 = 10'h100;
    bus.base_addr_1 = 10'h200;
    bus.req         = 2'b11;
    do_job(0, 10'h100, 1, 1'b0);
    step();
    do_job(1, 10'h200, 0, 1'b0);
    step();
    do_job(0, 10'h100, 1, 1'b0);
    bus.req = 2'b00;
    step();

    // Reset during FETCH row 7.
    bus.base_addr_0 = 10'h000;
    bus.req         = 2'b01;
    c0              = cyc;
    $display("job: owner=0 base=0x000 reset during fetch row 7, start_cycle=%0d", c0);
    exp_grant.push_back(mk(16'h0001, c0 + 1));
    for (int k = 0; k < 8; k++) exp_addr.push_back(mk(16'(32 * k), c0 + 2 + k));
    for (int k = 0; k < 7; k++) exp_row.push_back(mk(16'(k), c0 + 3 + k));
    repeat (9) step();
    rst_n = 1'b0;
    step();
    chk("midjob_reset_outputs", {8'b0, out_vec()}, 32'd0);
    bus.req         = 2'b10;
    bus.base_addr_1 = 10'h080;
    step();
    rst_n = 1'b1;
    do_job(1, 10'h080, 1, 1'b0);
    bus.req = 2'b00;
    step();

    // Engine never finishes.
    bus.base_addr_0 = 10'h000;
    bus.req         = 2'b01;
    do_job(0, 10'h000, 3, 1'b0);
    bus.req = 2'b00;
`ifdef FME_SCHED_WATCHDOG_EN
    chk("timeout_err_at_done", {31'b0, bus.timeout_err}, 32'd1);
    repeat (2) step();
    chk("timeout_err_sticky", {31'b0, bus.timeout_err}, 32'd1);
`else
    repeat (2) step();
    chk("timeout_err_tied_low", {31'b0, bus.timeout_err}, 32'd0);
`endif
    chk("final_idle", {31'b0, bus.busy}, 32'd0);

    repeat (3) step();
    left = exp_grant.size() + exp_addr.size() + exp_row.size() + exp_en.size() + exp_done.size();
    chk("leftover_expectations", 32'(left), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
